// File: rtl/array_mult_pkg.sv
// Shared widths and operand/product types for the array multiplier.
package array_mult_pkg;

  localparam int unsigned MULT_W = 32;
  localparam int unsigned PROD_W = 2 * MULT_W;

  typedef logic [MULT_W-1:0] operand_t;
  typedef logic [PROD_W-1:0] product_t;

endpackage

// File: rtl/array_mult_fa.sv
// 1-bit full adder cell used throughout the multiplier array.
module array_mult_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/array_mult32.sv
// Unsigned WIDTHxWIDTH carry-save array multiplier with registered product and valid.
// Define ARRAY_MULT_IN_REG_EN to register the operands first (2-cycle latency).
module array_mult32
  import array_mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   P
);

  logic [WIDTH-1:0]   w_x;
  logic [WIDTH-1:0]   w_y;
  logic               w_v;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] r_p;
  logic               r_valid;

`ifdef ARRAY_MULT_IN_REG_EN
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic             r_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
      r_v <= 1'b0;
    end else begin
      r_v <= in_valid;
      if (in_valid) begin
        r_x <= x;
        r_y <= y;
      end
    end
  end

  assign w_x = r_x;
  assign w_y = r_y;
  assign w_v = r_v;
`else
  assign w_x = x;
  assign w_y = y;
  assign w_v = in_valid;
`endif

  // Each row keeps sums (bit j at weight 2^(i+j)) and carries (weight 2^(i+j+1));
  // row i consumes row i-1's sums shifted down by one and its carries unshifted.
  for (genvar i = 0; i < WIDTH; i++) begin : g_row
    logic [WIDTH:0]   w_s;
    logic [WIDTH-1:0] w_c;
    if (i == 0) begin : g_first
      assign w_s = {1'b0, w_x & {WIDTH{w_y[0]}}};
      assign w_c = '0;
    end else begin : g_csa
      assign w_s[WIDTH] = 1'b0;
      for (genvar j = 0; j < WIDTH; j++) begin : g_cell
        array_mult_fa u_fa (
          .a   (w_x[j] & w_y[i]),
          .b   (g_row[i-1].w_s[j+1]),
          .cin (g_row[i-1].w_c[j]),
          .sum (w_s[j]),
          .cout(w_c[j])
        );
      end
    end
    assign w_prod[i] = w_s[0];
  end

  // Final ripple row resolves the remaining sum/carry vectors into the upper half.
  for (genvar k = 0; k < WIDTH - 1; k++) begin : g_rip
    logic w_ci;
    logic w_co;
    if (k == 0) begin : g_cin0
      assign w_ci = 1'b0;
    end else begin : g_cin
      assign w_ci = g_rip[k-1].w_co;
    end
    array_mult_fa u_fa (
      .a   (g_row[WIDTH-1].w_s[k+1]),
      .b   (g_row[WIDTH-1].w_c[k]),
      .cin (w_ci),
      .sum (w_prod[WIDTH+k]),
      .cout(w_co)
    );
  end

  // Top bit cannot carry out: the full product always fits in 2*WIDTH bits.
  assign w_prod[2*WIDTH-1] = g_row[WIDTH-1].w_s[WIDTH] ^ g_row[WIDTH-1].w_c[WIDTH-1]
                             ^ g_rip[WIDTH-2].w_co;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_v;
      if (w_v) begin
        r_p <= w_prod;
      end
    end
  end

  assign P         = r_p;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_array_mult32.sv
// Self-checking bench for array_mult32; latency follows ARRAY_MULT_IN_REG_EN.
module tb_array_mult32;

`ifdef ARRAY_MULT_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic [63:0] P;

  int checks;
  int errors;

  array_mult32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .x        (x),
    .y        (y),
    .out_valid(out_valid),
    .P        (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand pair for one cycle and return outputs once the latency has elapsed.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] p, output logic v);
    @(negedge clk);
    x = a;
    y = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    x = 'x;
    y = 'x;
    repeat (LAT - 1) @(negedge clk);
    p = P;
    v = out_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    x = '0;
    y = '0;
    #12;
    checks++;
    if (P !== 64'h0) begin
      errors++;
      $display("FAIL reset_p: got %h expected %h", P, 64'h0);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    logic [63:0] p;
    logic        v;
    run_one(32'h4, 32'h4, p, v);
    checks++;
    if (p !== 64'h10) begin
      errors++;
      $display("FAIL single_p: got %h expected %h", p, 64'h10);
    end
    checks++;
    if (v !== 1'b1) begin
      errors++;
      $display("FAIL single_valid: got %b expected 1", v);
    end
    // Valid must drop after one cycle while P holds despite X operands.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_valid_drop: cycle %0d got %b expected 0", c, out_valid);
      end
      checks++;
      if (P !== 64'h10) begin
        errors++;
        $display("FAIL single_hold: cycle %0d got %h expected %h", c, P, 64'h10);
      end
    end
  endtask

  task automatic test_corners;
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [63:0] ve [6];
    logic [63:0] p;
    logic        v;
    va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; ve[0] = 64'hFFFFFFFE00000001;
    va[1] = 32'h80000000; vb[1] = 32'h2;        ve[1] = 64'h0000000100000000;
    va[2] = 32'h0;        vb[2] = 32'hDEADBEEF; ve[2] = 64'h0;
    va[3] = 32'h1;        vb[3] = 32'hDEADBEEF; ve[3] = 64'h00000000DEADBEEF;
    va[4] = 32'h00010000; vb[4] = 32'h00010000; ve[4] = 64'h0000000100000000;
    va[5] = 32'h12345678; vb[5] = 32'h9ABCDEF0; ve[5] = 64'h0B00EA4E242D2080;
    for (int n = 0; n < 6; n++) begin
      run_one(va[n], vb[n], p, v);
      checks++;
      if (p !== ve[n] || v !== 1'b1) begin
        errors++;
        $display("FAIL corner_%0d: got P=%h v=%b expected P=%h v=1", n, p, v, ve[n]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [63:0] ve [3];
    va[0] = 32'd3;    vb[0] = 32'd5;    ve[0] = 64'd15;
    va[1] = 32'd7;    vb[1] = 32'd9;    ve[1] = 64'd63;
    va[2] = 32'hFFFF; vb[2] = 32'hFFFF; ve[2] = 64'hFFFE0001;
    for (int c = 0; c < 3 + LAT + 1; c++) begin
      @(negedge clk);
      if (c >= LAT && c < LAT + 3) begin
        checks++;
        if (out_valid !== 1'b1 || P !== ve[c-LAT]) begin
          errors++;
          $display("FAIL b2b_%0d: got P=%h v=%b expected P=%h v=1", c - LAT, P, out_valid,
                   ve[c-LAT]);
        end
      end else if (c >= LAT) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_tail: got v=%b expected 0", out_valid);
        end
      end
      if (c < 3) begin
        x = va[c];
        y = vb[c];
        in_valid = 1'b1;
      end else begin
        x = 'x;
        y = 'x;
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    x = 32'd1000;
    y = 32'd1000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (P !== 64'h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got P=%h v=%b expected P=0 v=0", P, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < LAT + 1; c++) begin
      @(negedge clk);
      checks++;
      if (P !== 64'h0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale: cycle %0d got P=%h v=%b expected P=0 v=0", c, P,
                 out_valid);
      end
    end
  endtask

  task automatic test_random;
    localparam int N = 1000;
    logic [63:0] ve [N];
    for (int c = 0; c < N + LAT; c++) begin
      @(negedge clk);
      if (c >= LAT) begin
        checks++;
        if (out_valid !== 1'b1 || P !== ve[c-LAT]) begin
          errors++;
          $display("FAIL random_%0d: got P=%h v=%b expected P=%h v=1", c - LAT, P, out_valid,
                   ve[c-LAT]);
        end
      end
      if (c < N) begin
        x = $urandom;
        y = $urandom;
        ve[c] = {32'h0, x} * {32'h0, y};
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_corners();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
